// File: rtl/reg_swap_sequencer.sv
// Shared swap engine for a small register file: round-robin arbitration among
// requesters, then a fixed READ_A/READ_B/WRITE_A/WRITE_B/DONE exchange via temporaries.
module reg_swap_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int REQUESTERS = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int GW        = $clog2(REQUESTERS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [REQUESTERS-1:0]    req,
    input  logic [REQUESTERS*AW-1:0] idx_a,
    input  logic [REQUESTERS*AW-1:0] idx_b,
    output logic [REQUESTERS-1:0]    ack,
    output logic                     busy,
    output logic [GW-1:0]            grant_id,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ_A  = 3'd1;
    localparam logic [2:0] S_READ_B  = 3'd2;
    localparam logic [2:0] S_WRITE_A = 3'd3;
    localparam logic [2:0] S_WRITE_B = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_rf [DEPTH];
    logic [WIDTH-1:0] r_temp_a;
    logic [WIDTH-1:0] r_temp_b;
    logic [AW-1:0]    r_a_q;
    logic [AW-1:0]    r_b_q;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    r_rr_ptr;

    logic             w_found;
    logic [GW-1:0]    w_winner;
    logic [GW-1:0]    w_cand;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            w_cand = GW'((int'(r_rr_ptr) + k) % REQUESTERS);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_temp_a   <= '0;
            r_temp_b   <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= GW'(REQUESTERS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_en) begin
                        r_rf[wr_addr] <= wr_data;
                    end
                    if (w_found) begin
                        r_a_q      <= idx_a[w_winner*AW +: AW];
                        r_b_q      <= idx_b[w_winner*AW +: AW];
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_state    <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    r_temp_a <= r_rf[r_a_q];
                    r_state  <= S_READ_B;
                end
                S_READ_B: begin
                    r_temp_b <= r_rf[r_b_q];
                    r_state  <= S_WRITE_A;
                end
                S_WRITE_A: begin
                    r_rf[r_a_q] <= r_temp_b;
                    r_state     <= S_WRITE_B;
                end
                S_WRITE_B: begin
                    r_rf[r_b_q] <= r_temp_a;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (r_state == S_DONE) begin
            ack[r_grant_id] = 1'b1;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant_id;
    assign rd_data  = r_rf[rd_addr];

endmodule

// File: tb/tb_reg_swap_sequencer.sv
// Scoreboard bench for reg_swap_sequencer: a reference model predicts grant order
// and register contents; a monitor pops expected grants whenever ack pulses.
module tb_reg_swap_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int REQ   = 4;
    localparam int AW    = 3;
    localparam int GW    = 2;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [REQ-1:0]      req = '0;
    logic [REQ*AW-1:0]   idx_a = '0;
    logic [REQ*AW-1:0]   idx_b = '0;
    logic [REQ-1:0]      ack;
    logic                busy;
    logic [GW-1:0]       grant_id;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [WIDTH-1:0]    wr_data = '0;
    logic [AW-1:0]       rd_addr = '0;
    logic [WIDTH-1:0]    rd_data;

    reg_swap_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REQUESTERS(REQ)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .idx_a(idx_a), .idx_b(idx_b),
        .ack(ack), .busy(busy), .grant_id(grant_id), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int posCount = 0;
    int expQ[$];
    logic [WIDTH-1:0] modelRf [DEPTH];
    int modelRr;
    int reqA [REQ];
    int reqB [REQ];

    always @(posedge clock) posCount <= posCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) modelRf[i] = '0;
        modelRr = REQ - 1;
    endtask

    // Serve the pending set in round-robin order, exchanging model registers per grant.
    task automatic predictRound(input logic [REQ-1:0] mask);
        logic [REQ-1:0] pending;
        logic [WIDTH-1:0] tmp;
        pending = mask;
        while (pending != '0) begin
            for (int k = 1; k <= REQ; k++) begin
                int c;
                c = (modelRr + k) % REQ;
                if (pending[c]) begin
                    tmp = modelRf[reqA[c]];
                    modelRf[reqA[c]] = modelRf[reqB[c]];
                    modelRf[reqB[c]] = tmp;
                    expQ.push_back(c);
                    modelRr = c;
                    pending[c] = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic driveIdx();
        for (int i = 0; i < REQ; i++) begin
            idx_a[i*AW +: AW] = AW'(reqA[i]);
            idx_b[i*AW +: AW] = AW'(reqB[i]);
        end
    endtask

    task automatic applyStimulus(input logic [REQ-1:0] mask);
        @(negedge clock);
        driveIdx();
        req = mask;
    endtask

    task automatic hostWrite(input int addr, input int data);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = WIDTH'(data);
        modelRf[addr] = WIDTH'(data);
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Each requester drops its request on the cycle it sees its ack.
    task automatic waitRound(input int budget, output int used);
        int p0;
        p0 = posCount;
        forever begin
            @(negedge clock);
            req = req & ~ack;
            if (expQ.size() == 0 && !busy && req == '0) break;
            if (posCount - p0 > budget) begin
                checks++;
                errors++;
                $display("[TB] FAIL round_timeout: still busy after %0d cycles, expected idle", budget);
                expQ.delete();
                req = '0;
                break;
            end
        end
        used = posCount - p0;
    endtask

    task automatic checkRegs();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            checkOutput($sformatf("rf[%0d]", a), 32'(rd_data), 32'(modelRf[a]));
        end
    endtask

    // Monitor: pops the next predicted grant whenever ack pulses.
    initial begin
        int busyCnt;
        logic [REQ-1:0] prevAck;
        int id;
        busyCnt = 0;
        prevAck = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                busyCnt = 0;
                prevAck = '0;
            end else begin
                busyCnt = busy ? busyCnt + 1 : 0;
                if (ack != '0) begin
                    checkOutput("ack_with_busy", 32'(busy), 32'd1);
                    checkOutput("ack_not_consecutive", 32'(prevAck), 32'd0);
                    checkOutput("ack_latency", 32'(busyCnt), 32'd5);
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_ack: got 0x%0h, expected none", ack);
                    end else begin
                        id = expQ.pop_front();
                        checkOutput("ack_onehot", 32'(ack), 32'(1) << id);
                        checkOutput("grant_id", 32'(grant_id), 32'(id));
                    end
                end
                prevAck = ack;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int used;
        logic [REQ-1:0] mask;
        modelReset();
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        checkRegs();
        @(negedge clock);
        reset_n = 1'b1;

        // Single swap
        hostWrite(1, 8'h11);
        hostWrite(2, 8'h22);
        reqA[0] = 1; reqB[0] = 2;
        predictRound(4'b0001);
        applyStimulus(4'b0001);
        waitRound(60, used);
        checkOutput("single_cycles", 32'(used), 32'd6);
        checkRegs();

        // All four held: fairness and back-to-back throughput
        for (int i = 0; i < DEPTH; i++) hostWrite(i, 8'h30 + i);
        reqA[0] = 0; reqB[0] = 1; reqA[1] = 2; reqB[1] = 3;
        reqA[2] = 4; reqB[2] = 5; reqA[3] = 6; reqB[3] = 7;
        predictRound(4'b1111);
        applyStimulus(4'b1111);
        waitRound(200, used);
        checkOutput("fair_cycles", 32'(used), 32'd24);
        checkRegs();

        // Same index on both sides
        hostWrite(5, 8'hA5);
        reqA[2] = 5; reqB[2] = 5;
        predictRound(4'b0100);
        applyStimulus(4'b0100);
        waitRound(60, used);
        checkRegs();

        // Host write dropped during WRITE_A, then accepted in IDLE
        reqA[1] = 0; reqB[1] = 4;
        predictRound(4'b0010);
        applyStimulus(4'b0010);
        @(posedge clock);
        repeat (3) @(negedge clock);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hFF;
        @(negedge clock);
        wr_en = 1'b0;
        waitRound(60, used);
        checkRegs();
        hostWrite(3, 8'hFF);
        checkRegs();

        // Index change after grant is ignored
        hostWrite(6, 8'h66);
        reqA[3] = 1; reqB[3] = 2;
        predictRound(4'b1000);
        applyStimulus(4'b1000);
        @(posedge clock);
        @(negedge clock);
        reqB[3] = 6;
        driveIdx();
        waitRound(60, used);
        checkRegs();

        // Reset during WRITE_B abandons the swap
        reqA[2] = 0; reqB[2] = 7;
        applyStimulus(4'b0100);
        @(posedge clock);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        req = '0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_ack", 32'(ack), 32'd0);
        checkOutput("midreset_grant_id", 32'(grant_id), 32'd0);
        modelReset();
        checkRegs();
        @(negedge clock);
        reset_n = 1'b1;
        hostWrite(0, 8'h0A);
        hostWrite(7, 8'h7B);
        reqA[0] = 0; reqB[0] = 7; reqA[3] = 3; reqB[3] = 0;
        predictRound(4'b1001);
        applyStimulus(4'b1001);
        waitRound(100, used);
        checkOutput("postreset_cycles", 32'(used), 32'd12);
        checkRegs();

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) hostWrite($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
            for (int i = 0; i < REQ; i++) begin
                reqA[i] = $urandom_range(0, DEPTH - 1);
                reqB[i] = $urandom_range(0, DEPTH - 1);
            end
            mask = REQ'($urandom_range(1, (1 << REQ) - 1));
            predictRound(mask);
            applyStimulus(mask);
            waitRound(200, used);
            checkOutput("rand_cycles", 32'(used), 32'(6 * $countones(mask)));
            checkRegs();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
